seven_seg_scan_driver: RTL and testbench

//  Encodes a multi-digit hex value into active-low 7-segment patterns and time-multiplexes them across
//  NUM_DIGITS common-anode digits. Sits between core datapath and board display pins.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seven_seg_encode.sv | 33 +++
 rtl/seven_seg_scan_driver.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment display definitions: segment vector type, fixed patterns and scan FSM states.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, 0 = segment on

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  typedef enum logic {
    GUARD,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/seven_seg_encode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seven_seg_encode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous loads.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits at commit.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dash_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] TC   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dash;
    logic [NUM_DIGITS-1:0]   point;
  } disp_t;

  scan_state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] index_q, index_d;
  logic          tc, wrap, commit;

  disp_t pending_q, active_q, capture, commit_val;
  logic  pending_flag_q;

  seg_t                  enc_seg, seg_d;
  logic [3:0]            nibble;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Scan sequencing: GUARD is always the single prescaler-zero cycle of each digit.
  always_comb begin
    tc      = (presc_q == TC);
    presc_d = tc ? '0 : presc_q + PW'(1);
    state_d = state_q;
    index_d = index_q;
    wrap    = 1'b0;
    case (state_q)
      GUARD: state_d = SHOW;
      SHOW: begin
        if (tc) begin
          state_d = GUARD;
          wrap    = (index_q == LAST);
          index_d = wrap ? '0 : index_q + IW'(1);
        end
      end
      default: state_d = GUARD;
    endcase
  end

  assign commit  = wrap && pending_flag_q;
  assign capture = '{value: value, blank: blank_mask, dash: dash_mask, point: dp_mask};

  always_comb begin
    commit_val = pending_q;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb_scan
      logic scanning;
      scanning = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (scanning) begin
          if (pending_q.dash[i] || (pending_q.value[4*i +: 4] != 4'h0)) scanning = 1'b0;
          else commit_val.blank[i] = 1'b1;
        end
      end
    end
`endif
  end

  // Outputs are precomputed from the next state so the registered pins line up with state_q.
  assign nibble = active_q.value[4*int'(index_d) +: 4];

  seven_seg_encode u_encode (
    .nibble (nibble),
    .seg    (enc_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if ((state_d == SHOW) && !active_q.blank[index_d]) begin
      an_d[index_d] = 1'b0;
      seg_d         = active_q.dash[index_d] ? SEG_DASH : enc_seg;
      dp_d          = ~active_q.point[index_d];
    end
  end

  // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= GUARD;
      presc_q        <= '0;
      index_q        <= '0;
      pending_flag_q <= 1'b0;
      pending_q      <= '{value: '0, blank: '1, dash: '0, point: '0};
      active_q       <= '{value: '0, blank: '1, dash: '0, point: '0};
      seg            <= SEG_BLANK;
      dp             <= 1'b1;
      an             <= '1;
      frame_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      index_q    <= index_d;
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_done <= wrap;
      if (load) pending_q <= capture;
      if (load) pending_flag_q <= 1'b1;
      else if (commit) pending_flag_q <= 1'b0;
      // A load on the commit edge lands in pending; active takes the older pending contents.
      if (commit) active_q <= commit_val;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seven_seg_scan_driver;
  import seven_seg_pkg::*;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk;
  logic          reset_n;
  logic          load;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank_mask, dash_mask, dp_mask;
  seg_t          seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dash_mask  (dash_mask),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d,
                         input logic [3:0] p);
    @(negedge clk);
    value = v; blank_mask = b; dash_mask = d; dp_mask = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    value = 16'hDEAD; blank_mask = 4'h5; dash_mask = 4'hA; dp_mask = 4'h3;
  endtask

  // Steps negedges until frame_done is seen (bounded); tallies lit anodes and disallowed segments.
  task automatic run_to_fd(input seg_t allow, output int cnt, output int lit, output int bad);
    cnt = 0; lit = 0; bad = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (an !== 4'hF) lit++;
      if ((seg !== allow) && (seg !== SEG_BLANK)) bad++;
      if (frame_done === 1'b1) break;
    end
  endtask

  // Called at the frame_done sample (GUARD of digit 0); walks one full frame.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [15:0] ans,
                             input logic [3:0] dps);
    check({tag, "_guard0_an"}, 32'(an), 32'hF);
    for (int d = 0; d < ND; d++) begin
      @(negedge clk);
      check($sformatf("%s_d%0d_an", tag, d), 32'(an), 32'(ans[4*d +: 4]));
      check($sformatf("%s_d%0d_seg", tag, d), 32'(seg), 32'(segs[7*d +: 7]));
      check($sformatf("%s_d%0d_dp", tag, d), 32'(dp), 32'(dps[d]));
      repeat (RD - 2) @(negedge clk);
      @(negedge clk);
      check($sformatf("%s_guard%0d_an", tag, d + 1), 32'(an), 32'hF);
      check($sformatf("%s_guard%0d_seg", tag, d + 1), 32'(seg), 32'h7F);
    end
    check({tag, "_frame_done"}, 32'(frame_done), 32'h1);
  endtask

  initial begin
    int cnt, lit, bad;
    load = 1'b0; value = '0; blank_mask = '0; dash_mask = '0; dp_mask = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: idle after reset stays dark, frame_done every 16 clocks
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check("t1_period_first", 32'(cnt), 32'd16);
    check("t1_lit", 32'(lit), 32'd0);
    check("t1_seg", 32'(bad), 32'd0);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check("t1_period", 32'(cnt), 32'd16);
    check("t1_lit2", 32'(lit), 32'd0);

    // 2: plain hex value
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check("t2_no_early", 32'(lit), 32'd0);
    check_frame("t2", {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'hF);

    // 3: dash, blank and decimal point masks
    do_load(16'h12AF, 4'b1000, 4'b0100, 4'b1001);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check_frame("t3", {7'h7F, 7'h3F, 7'h08, 7'h0E}, 16'hFBDE, 4'b1110);

    // 4: last load before commit wins
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check_frame("t4a", {7'h79, 7'h79, 7'h79, 7'h79}, 16'h7BDE, 4'hF);
    do_load(16'h3333, 4'h0, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    run_to_fd(7'h79, cnt, lit, bad);
    check("t4_before_commit", 32'(bad), 32'd0);
    run_to_fd(7'h24, cnt, lit, bad);
    check("t4_after_commit", 32'(bad), 32'd0);
    check("t4_period", 32'(cnt), 32'd16);

    // 5: asynchronous reset mid-SHOW of digit 2
    repeat (2 * RD + 1) @(negedge clk);
    check("t5_pre_an", 32'(an), 32'hB);
    check("t5_pre_seg", 32'(seg), 32'h24);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_an", 32'(an), 32'hF);
    check("t5_rst_seg", 32'(seg), 32'h7F);
    check("t5_rst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    run_to_fd(SEG_BLANK, cnt, lit, bad);
    check("t5_restart_period", 32'(cnt), 32'd16);
    check("t5_stays_blank", 32'(lit), 32'd0);

    // 6: zero digits, with and without leading-zero blanking
    do_load(16'h0050, 4'h0, 4'h0, 4'hF);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("t6a", {7'h7F, 7'h7F, 7'h12, 7'h40}, 16'hFFDE, 4'b1100);
`else
    check_frame("t6a", {7'h40, 7'h40, 7'h12, 7'h40}, 16'h7BDE, 4'b0000);
`endif
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    run_to_fd(SEG_BLANK, cnt, lit, bad);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("t6b", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE, 4'hF);
`else
    check_frame("t6b", {7'h40, 7'h40, 7'h40, 7'h40}, 16'h7BDE, 4'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
